// File: rtl/order_arbiter_if.sv
// -----------------------------------------------------------------------------
// order_arbiter_if
// Groups the order-source request bus and the engine-facing price bus shared
// by the order arbiter and whatever drives / consumes it.
//
//   req_valid  [NUM_SRC]          per-source order pending
//   req_buy    [NUM_SRC*PRICE_W]  packed buy prices, source i at [i*PRICE_W +: PRICE_W]
//   req_sell   [NUM_SRC*PRICE_W]  packed sell prices, same packing
//   req_ready  [NUM_SRC]          one-hot, one-cycle accept pulse
//   out_buy    [PRICE_W]          buy price presented to the matching engine
//   out_sell   [PRICE_W]          sell price presented to the matching engine
//   out_valid                     one-cycle pulse when a new pair is presented
//   out_src    [3]                source index owning out_buy/out_sell
//
// Modports: master = order sources / engine side, slave = arbiter.
// -----------------------------------------------------------------------------
interface order_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int PRICE_W = 8
);
    logic [NUM_SRC-1:0]         req_valid;
    logic [NUM_SRC*PRICE_W-1:0] req_buy;
    logic [NUM_SRC*PRICE_W-1:0] req_sell;
    logic [NUM_SRC-1:0]         req_ready;
    logic [PRICE_W-1:0]         out_buy;
    logic [PRICE_W-1:0]         out_sell;
    logic                       out_valid;
    logic [2:0]                 out_src;

    modport master (
        output req_valid, req_buy, req_sell,
        input  req_ready, out_buy, out_sell, out_valid, out_src
    );

    modport slave (
        input  req_valid, req_buy, req_sell,
        output req_ready, out_buy, out_sell, out_valid, out_src
    );
endinterface

// File: rtl/order_arbiter.sv
// -----------------------------------------------------------------------------
// order_arbiter
// Round-robin scheduler sharing one matching engine between NUM_SRC order
// sources. Each transaction takes one buy/sell pair from the granted source,
// presents it to the engine, samples the engine's match flag one cycle later
// and attributes any fill to the source. A configurable idle gap follows each
// transaction, and no new grant is made while the trade counter asserts halt.
//
// Ports:
//   clk_50       system clock
//   reset_n      asynchronous active-low reset
//   bus          order_arbiter_if.slave (request bus + engine price bus)
//   halt         halt request from the trade counter
//   match_in     engine match flag, sampled in WAIT
//   fill_valid   one-cycle pulse when a match is attributed
//   fill_src     source index owning the fill
//   issue_count  issued transactions, saturating at 255
//   arb_state    FSM state (IDLE=0 ISSUE=1 WAIT=2 GAP=3 HALTED=4)
//
// Optional feature, macro ORDER_ARB_PRIORITY_EN: source 0 wins every grant it
// requests, except that after 4 consecutive source-0 grants with another source
// pending, one round-robin grant with source 0 masked is forced. rr_ptr then
// advances only on round-robin grants.
// -----------------------------------------------------------------------------
module order_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int PRICE_W    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk_50,
    input  logic                reset_n,
    order_arbiter_if.slave      bus,
    input  logic                halt,
    input  logic                match_in,
    output logic                fill_valid,
    output logic [2:0]          fill_src,
    output logic [7:0]          issue_count,
    output logic [2:0]          arb_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic [2:0]       rr_ptr;
    logic [GAP_W-1:0] gap_cnt;

    // Round-robin scan works on a fixed 8-bit view so a 3-bit index always fits.
    logic [7:0]       scan_vec;
    logic [2:0]       grant;
    logic             grant_found;

`ifdef ORDER_ARB_PRIORITY_EN
    logic [2:0]       prio_cnt;     // consecutive source-0 grants, saturates at 4
    logic             prio_grant;
    logic             starve_guard;
    logic             rr_upd;       // current transaction came from the round-robin scan
`endif

    // NOTE: every variable gets a default at the top of the always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        scan_vec    = 8'(bus.req_valid);
        grant       = '0;
        grant_found = 1'b0;
`ifdef ORDER_ARB_PRIORITY_EN
        starve_guard = (prio_cnt == 3'd4) && (|bus.req_valid[NUM_SRC-1:1]);
        prio_grant   = bus.req_valid[0] && !starve_guard;
        if (starve_guard) scan_vec[0] = 1'b0;
`endif
        // Descending offset so the smallest offset from rr_ptr is the last,
        // and therefore winning, assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (scan_vec[3'((int'(rr_ptr) + i) % NUM_SRC)]) begin
                grant       = 3'((int'(rr_ptr) + i) % NUM_SRC);
                grant_found = 1'b1;
            end
        end
`ifdef ORDER_ARB_PRIORITY_EN
        if (prio_grant) begin
            grant       = '0;
            grant_found = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
            bus.out_buy   <= '0;
            bus.out_sell  <= '0;
            bus.out_src   <= '0;
            bus.out_valid <= 1'b0;
            bus.req_ready <= '0;
            fill_valid    <= 1'b0;
            fill_src      <= '0;
            issue_count   <= '0;
`ifdef ORDER_ARB_PRIORITY_EN
            prio_cnt      <= '0;
            rr_upd        <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; a state sets them for exactly one cycle.
            bus.out_valid <= 1'b0;
            bus.req_ready <= '0;
            fill_valid    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (halt) begin
                        state <= ST_HALTED;
                    end else if (grant_found) begin
                        bus.out_buy   <= bus.req_buy[int'(grant)*PRICE_W +: PRICE_W];
                        bus.out_sell  <= bus.req_sell[int'(grant)*PRICE_W +: PRICE_W];
                        bus.out_src   <= grant;
                        // Registered here so both pulses are high during ISSUE.
                        bus.out_valid <= 1'b1;
                        bus.req_ready <= NUM_SRC'(8'd1 << grant);
                        state         <= ST_ISSUE;
`ifdef ORDER_ARB_PRIORITY_EN
                        rr_upd <= !prio_grant;
                        if (prio_grant)
                            prio_cnt <= (prio_cnt == 3'd4) ? 3'd4 : prio_cnt + 3'd1;
                        else
                            prio_cnt <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
`ifdef ORDER_ARB_PRIORITY_EN
                    if (rr_upd)
                        rr_ptr <= 3'((int'(bus.out_src) + 1) % NUM_SRC);
`else
                    rr_ptr <= 3'((int'(bus.out_src) + 1) % NUM_SRC);
`endif
                    if (issue_count != 8'hFF) issue_count <= issue_count + 8'd1;
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (match_in) begin
                        fill_valid <= 1'b1;
                        fill_src   <= bus.out_src;
                    end
                    gap_cnt <= '0;
                    if (GAP_CYCLES > 0) state <= ST_GAP;
                    else                state <= halt ? ST_HALTED : ST_IDLE;
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= halt ? ST_HALTED : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_HALTED: begin
                    if (!halt) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_order_arbiter.sv
// -----------------------------------------------------------------------------
// tb_order_arbiter
// Directed bench for order_arbiter (NUM_SRC=4, PRICE_W=8, GAP_CYCLES=2).
// Expected issues and fills are queued when stimulus is driven and popped when
// the DUT presents them. Source i offers buy=0x40+2i, sell=0x3F+i.
// -----------------------------------------------------------------------------
module tb_order_arbiter;

    localparam int NUM_SRC = 4;
    localparam int PRICE_W = 8;

    typedef struct {
        logic [2:0] src;
        logic [7:0] buy;
        logic [7:0] sell;
    } issue_t;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic       halt;
    logic       match_in;
    logic       fill_valid;
    logic [2:0] fill_src;
    logic [7:0] issue_count;
    logic [2:0] arb_state;

    order_arbiter_if #(.NUM_SRC(NUM_SRC), .PRICE_W(PRICE_W)) bus ();

    order_arbiter #(.NUM_SRC(NUM_SRC), .PRICE_W(PRICE_W), .GAP_CYCLES(2)) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .bus         (bus),
        .halt        (halt),
        .match_in    (match_in),
        .fill_valid  (fill_valid),
        .fill_src    (fill_src),
        .issue_count (issue_count),
        .arb_state   (arb_state)
    );

    always #5 clk_50 = ~clk_50;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_issue_cyc = 0;
    int         fill_cnt = 0;
    int         issue_seen = 0;
    issue_t     exp_q[$];
    logic [2:0] fill_q[$];

    always @(posedge clk_50) cyc++;
    always @(negedge clk_50) if (fill_valid) fill_cnt++;
    always @(negedge clk_50) if (bus.out_valid) issue_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    function automatic logic [7:0] buy_of(input int s);
        return 8'h40 + 8'(2 * s);
    endfunction

    function automatic logic [7:0] sell_of(input int s);
        return 8'h3F + 8'(s);
    endfunction

    task automatic push_issue(input int s);
        issue_t e;
        e.src  = 3'(s);
        e.buy  = buy_of(s);
        e.sell = sell_of(s);
        exp_q.push_back(e);
    endtask

    // Advance at least one cycle, then wait (bounded) for the next out_valid.
    task automatic expect_issue(input bit chk_gap);
        int     n = 0;
        issue_t e;
        logic [NUM_SRC-1:0] rdy;
        do begin
            tick(1);
            n++;
        end while (!bus.out_valid && n < 40);
        if (!bus.out_valid) begin
            check("issue_timeout", 32'(bus.out_valid), 1);
        end else begin
            e   = exp_q.pop_front();
            rdy = NUM_SRC'(4'b0001 << e.src);
            check("out_src", 32'(bus.out_src), 32'(e.src));
            check("out_buy", 32'(bus.out_buy), 32'(e.buy));
            check("out_sell", 32'(bus.out_sell), 32'(e.sell));
            check("req_ready", 32'(bus.req_ready), 32'(rdy));
            if (chk_gap) check("issue_period", 32'(cyc - last_issue_cyc), 5);
            last_issue_cyc = cyc;
        end
    endtask

    initial begin
        int c0;
        int target;
        int n;

        reset_n       = 1'b0;
        halt          = 1'b0;
        match_in      = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.req_buy[i*PRICE_W +: PRICE_W]  = buy_of(i);
            bus.req_sell[i*PRICE_W +: PRICE_W] = sell_of(i);
        end

        // Reset values
        #1;
        check("rst_prices", {bus.out_buy, bus.out_sell, bus.out_src, fill_src}, 0);
        check("rst_ctrl", {issue_count, bus.req_ready, bus.out_valid, fill_valid, arb_state}, 0);
        tick(2);
        reset_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle", {bus.out_valid, bus.req_ready, issue_count, arb_state}, 0);
        end

        // Round-robin with all sources valid
        bus.req_valid = 4'hF;
        push_issue(0); push_issue(1); push_issue(2); push_issue(3); push_issue(0);
        expect_issue(0);
        for (int i = 0; i < 4; i++) expect_issue(1);
        bus.req_valid = '0;
        tick(4);
        check("rr_issue_count", 32'(issue_count), 5);
        check("rr_back_idle", 32'(arb_state), 0);

        // Fill attribution to source 2 (rr_ptr=1)
        bus.req_valid = 4'b0100;
        push_issue(2);
        expect_issue(0);
        bus.req_valid = '0;
        match_in = 1'b1;
        fill_q.push_back(3'd2);
        tick(2);
        match_in = 1'b0;
        check("fill_pulse", 32'(fill_valid), 1);
        check("fill_src", 32'(fill_src), 32'(fill_q.pop_front()));
        tick(1);
        check("fill_one_shot", 32'(fill_valid), 0);
        tick(1);

        // No match: source 1 (rr_ptr=3 scans 3,0,1), no fill pulse
        bus.req_valid = 4'b0010;
        push_issue(1);
        expect_issue(0);
        bus.req_valid = '0;
        c0 = fill_cnt;
        tick(5);
        check("no_fill", 32'(fill_cnt - c0), 0);

        // Halt during ISSUE: transaction completes, fill still reported
        bus.req_valid = 4'hF;
        push_issue(2);
        expect_issue(0);
        halt     = 1'b1;
        match_in = 1'b1;
        fill_q.push_back(3'd2);
        tick(2);
        match_in = 1'b0;
        check("halt_fill_pulse", 32'(fill_valid), 1);
        check("halt_fill_src", 32'(fill_src), 32'(fill_q.pop_front()));
        check("halt_in_gap", 32'(arb_state), 3);
        tick(2);
        check("halted_state", 32'(arb_state), 4);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("halted_no_grant", {bus.req_ready, bus.out_valid}, 0);
        end
        check("halted_hold_price", {bus.out_buy, bus.out_sell}, {buy_of(2), sell_of(2)});
        halt = 1'b0;
        push_issue(3);
        expect_issue(0);

        // Saturation of issue_count
        target = issue_seen + 300;
        n = 0;
        while (issue_seen < target && n < 2000) begin
            tick(1);
            n++;
        end
        check("sat_issues_done", 32'(issue_seen >= target), 1);
        check("sat_issue_count", 32'(issue_count), 255);

        // Async reset in the middle of WAIT with a match pending
        match_in = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!bus.out_valid && n < 20);
        tick(1);
        check("mid_wait_state", 32'(arb_state), 2);
        c0 = fill_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_prices", {bus.out_buy, bus.out_sell, bus.out_src, fill_src}, 0);
        check("async_rst_ctrl", {issue_count, bus.req_ready, bus.out_valid, fill_valid, arb_state}, 0);
        bus.req_valid = '0;
        match_in      = 1'b0;
        #3 reset_n = 1'b1;
        tick(5);
        check("rst_no_fill", 32'(fill_cnt - c0), 0);
        check("rst_count_zero", 32'(issue_count), 0);

        // Sources 0 and 3 constantly valid, rr_ptr=0 after reset
        bus.req_valid = 4'b1001;
`ifdef ORDER_ARB_PRIORITY_EN
        for (int k = 0; k < 2; k++) begin
            push_issue(0); push_issue(0); push_issue(0); push_issue(0); push_issue(3);
        end
`else
        for (int k = 0; k < 5; k++) begin
            push_issue(0); push_issue(3);
        end
`endif
        expect_issue(0);
        for (int i = 0; i < 9; i++) expect_issue(1);
        bus.req_valid = '0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/order_arbiter.md
Name: order_arbiter

Overview:
- Round-robin scheduler that shares the single matching engine between NUM_SRC independent order sources (generators, keypad entry, replay).
- Accepts one buy/sell price pair per transaction over a valid/ready handshake and drives the engine's buy/sell price inputs.
- Samples the engine's match result and attributes each fill to its originating source.
- Stops issuing while the trade counter asserts halt.

Parameters:
- NUM_SRC, 4: number of order sources; legal range 2..8.
- PRICE_W, 8: price width in bits.
- GAP_CYCLES, 2: idle cycles inserted after each transaction before the next grant; 0 means no gap.

Ports:
- clk_50, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_SRC: bit i high means source i has an order pending.
- req_buy, input, NUM_SRC*PRICE_W: buy price of source i in bits [i*PRICE_W +: PRICE_W].
- req_sell, input, NUM_SRC*PRICE_W: sell price of source i, packed the same way.
- req_ready, output, NUM_SRC: one-hot, one-cycle pulse that accepts source i's order.
- halt, input, 1: halt request from the trade counter.
- match_in, input, 1: engine match flag, sampled in the WAIT state.
- out_buy, output, PRICE_W: buy price to the engine; held between issues.
- out_sell, output, PRICE_W: sell price to the engine; held between issues.
- out_valid, output, 1: one-cycle pulse when a new pair is presented.
- out_src, output, 3: index of the source that owns the current out_buy/out_sell.
- fill_valid, output, 1: one-cycle pulse when a match is attributed to a source.
- fill_src, output, 3: source index that owns the fill.
- issue_count, output, 8: total issued transactions; saturates at 255.
- arb_state, output, 3: current FSM state encoding.

Behaviour:
- Reset values (asynchronous, reset_n low), all outputs:
  - out_buy, out_sell, out_src, fill_src, issue_count: 0.
  - req_ready, out_valid, fill_valid: 0.
  - FSM in IDLE; rr_ptr = 0; gap counter = 0.
- Reset mid-transaction aborts it with no ready and no fill pulse.
- State encodings: IDLE=0, ISSUE=1, WAIT=2, GAP=3, HALTED=4.
- IDLE:
  - If halt=1, go to HALTED. Halt has priority over pending requests.
  - Otherwise, if any req_valid bit is set, select grant g: the first set bit found scanning cyclically from rr_ptr upward.
  - Register out_buy/out_sell from source g's fields and set out_src=g, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE (1 cycle):
  - out_valid=1 and req_ready[g]=1; the transfer completes in this cycle.
  - Sources must hold valid and prices stable until ready is seen.
  - rr_ptr <= (g+1) mod NUM_SRC.
  - issue_count increments unless it is already 255.
  - Go to WAIT.
- WAIT (1 cycle):
  - Sample match_in. If it is 1, fill_valid pulses in the next cycle with fill_src=g.
  - Then go to GAP if GAP_CYCLES>0; otherwise go to IDLE, or to HALTED if halt=1.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE, or to HALTED if halt=1.
  - req_valid is ignored throughout GAP.
- HALTED:
  - No grants are made; outputs hold their last prices.
  - Go to IDLE in the cycle after halt is sampled low.
- Halt asserted during ISSUE, WAIT or GAP does not abort the transaction; the fill is still reported, and the FSM enters HALTED at the end of the transaction.
- Minimum transaction period is 3+GAP_CYCLES cycles. Latency from req_valid seen in IDLE to out_valid is 1 cycle.
- A source that deasserts req_valid before its grant is skipped; there is no stale capture.
- rr_ptr wraps from NUM_SRC-1 to 0.
- out_src/fill_src are zero-extended to 3 bits.

Optional Feature:
- Macro: ORDER_ARB_PRIORITY_EN.
- When defined:
  - Source 0 is high priority: if req_valid[0]=1 in IDLE, it wins regardless of rr_ptr.
  - Starvation guard: after 4 consecutive source-0 grants while another source is pending, the next grant uses the round-robin scan with bit 0 masked. The consecutive counter resets on any non-0 grant.
  - rr_ptr updates only on round-robin grants.
- When undefined: pure round-robin, and no priority logic or counter is synthesized.

Test Plan:
- Reset then idle: with req_valid=0 for 20 cycles, out_valid, req_ready, issue_count and arb_state all stay 0.
- Round-robin: NUM_SRC=4, all valid constantly, GAP_CYCLES=2 → grants 0,1,2,3,0, with out_valid pulses exactly 5 cycles apart; src1 buy=0x42/sell=0x40 appears on out_buy/out_sell in the second issue.
- Fill attribution: grant src2 and drive match_in=1 in WAIT → fill_valid pulses once with fill_src=2. With match_in=0, no pulse occurs.
- Halt mid-transaction: assert halt during ISSUE → WAIT and GAP complete and the fill is still reported; arb_state=4 with no further req_ready. Deasserting halt resumes with the grant at rr_ptr.
- Saturation and async reset: 300 issues → issue_count=255. Pulse reset_n low mid-WAIT → all outputs 0 immediately, with no fill_valid.
- With ORDER_ARB_PRIORITY_EN defined and src0 and src3 constantly valid → grants 0,0,0,0,3,0,0,0,0,3.
